pos_sync_sender: RTL and testbench
==================================

Name: pos_sync_sender

Overview:
- Source-side half of the toggle req/ack handshake that moves mouse position words from the 100 MHz mouse domain into the 40 MHz display domain.
- Captures new xpos/ypos samples and holds them stable on the crossing bus while a request toggle is outstanding.
- Waits for the receiver's acknowledge toggle, synchronised into this domain, before launching the next word.
- Updates that arrive while a transfer is outstanding are coalesced, latest wins, and counted when overwritten.

Parameters:
- WIDTH, 12, bit width of each position coordinate.
- SYNC_STAGES, 2, flip-flop stages on ack_toggle_in; legal range 2..4.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk100MHz  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- xpos_in  input  WIDTH  new x sample, qualified by valid_in.
- ypos_in  input  WIDTH  new y sample, qualified by valid_in.
- valid_in  input  1  one-cycle strobe marking a new sample.
- ack_toggle_in  input  1  receiver ack toggle; asynchronous to clk100MHz.
- xpos_hold  output  WIDTH  x word driven across the domain boundary; stable while busy.
- ypos_hold  output  WIDTH  y word driven across the domain boundary; stable while busy.
- req_toggle  output  1  request toggle; flips once per launched word.
- busy  output  1  high while a transfer is outstanding (state SEND).
- drop_cnt  output  CNT_W  saturating count of overwritten pending samples.

Behaviour:
- Reset, synchronous: state IDLE; xpos_hold=ypos_hold=0; req_toggle=0; busy=0; drop_cnt=0; pending_valid=0; pending regs=0; all sync flops=0. Reset asserted mid-transfer abandons the transfer; no word is re-sent.
- ack_sync is ack_toggle_in after SYNC_STAGES flops. It is used only as a comparison against req_toggle. done = (ack_sync == req_toggle).
- IDLE:
  - valid_in=1 at edge N: hold regs <= inputs, req_toggle flips, state <= SEND.
  - New values and busy=1 are visible from cycle N+1.
  - ack_sync is ignored in IDLE.
- SEND, hold regs never change except at a completing edge:
  - valid_in=1 and not done: pending regs <= inputs, pending_valid <= 1. If pending_valid was already 1, drop_cnt++ (saturating at all-ones).
  - done, no pending, no valid_in: state <= IDLE, busy drops next cycle.
  - done and pending_valid, no valid_in: hold <= pending, req_toggle flips, pending_valid <= 0, stay SEND.
  - done and valid_in on the same edge: hold <= inputs (newer wins), req_toggle flips, pending_valid <= 0, stay SEND. If pending_valid was 1, drop_cnt++.
- Minimum turnaround after the receiver toggles ack is SYNC_STAGES cycles to see done, plus 1 edge to relaunch.
- Invariant: req_toggle flips only on edges where the hold regs load, so data is stable at least 1 cycle before the toggle is observable downstream.
- Width: hold and pending regs are exactly WIDTH bits; no arithmetic on data.

Test Plan:
- Reset: rst high 3 cycles with valid_in=1 and x=0x123 -> all outputs 0, busy=0, req_toggle=0 after release.
- Single transfer:
  - Stimulus: valid_in pulse with x=0x2A0, y=0x1F4; next cycle hold=0x2A0/0x1F4, req_toggle=1, busy=1.
  - Response: hold stays stable until ack_toggle_in is driven to 1; busy falls exactly SYNC_STAGES+1 cycles after that.
- Coalescing:
  - Stimulus: during SEND, pulse x=0x010, then x=0x020, then x=0x030.
  - Response: drop_cnt=2. After ack, hold=0x030, req_toggle returns to 0, busy stays 1.
- Simultaneous: valid_in with x=0x055 on the exact edge done becomes true while pending x=0x044 -> hold=0x055, drop_cnt increments by 1, pending cleared.
- Saturation: with CNT_W=8, 300 overwrites during one SEND -> drop_cnt=255 and holds.
- Reset mid-transfer: assert rst while busy with pending valid -> next cycle IDLE, hold=0, drop_cnt=0. Subsequent valid_in launches with req_toggle=1.

Source files
------------

// File: rtl/pos_sync_sender.sv
// Source side of a toggle req/ack crossing for mouse position words.
// Holds the launched word stable until the synchronised ack matches the request toggle.
module pos_sync_sender #(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk100MHz,
    input  logic             rst,
    input  logic [WIDTH-1:0] xpos_in,
    input  logic [WIDTH-1:0] ypos_in,
    input  logic             valid_in,
    input  logic             ack_toggle_in,
    output logic [WIDTH-1:0] xpos_hold,
    output logic [WIDTH-1:0] ypos_hold,
    output logic             req_toggle,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_reg, state_next;
    logic [SYNC_STAGES-1:0] ack_sync_reg;
    logic [WIDTH-1:0]       xpos_hold_reg, xpos_hold_next;
    logic [WIDTH-1:0]       ypos_hold_reg, ypos_hold_next;
    logic [WIDTH-1:0]       xpos_pend_reg, xpos_pend_next;
    logic [WIDTH-1:0]       ypos_pend_reg, ypos_pend_next;
    logic                   pend_valid_reg, pend_valid_next;
    logic                   req_reg, req_next;
    logic [CNT_W-1:0]       drop_reg, drop_next;
    logic [CNT_W-1:0]       drop_inc;
    logic                   done;

    // The synchronised ack is only ever compared with our own request toggle.
    assign done     = (ack_sync_reg[SYNC_STAGES-1] == req_reg);
    assign drop_inc = (drop_reg == {CNT_W{1'b1}}) ? drop_reg : drop_reg + CNT_W'(1);

    always_comb begin
        state_next      = state_reg;
        xpos_hold_next  = xpos_hold_reg;
        ypos_hold_next  = ypos_hold_reg;
        xpos_pend_next  = xpos_pend_reg;
        ypos_pend_next  = ypos_pend_reg;
        pend_valid_next = pend_valid_reg;
        req_next        = req_reg;
        drop_next       = drop_reg;
        case (state_reg)
            IDLE: begin
                if (valid_in) begin
                    xpos_hold_next = xpos_in;
                    ypos_hold_next = ypos_in;
                    req_next       = ~req_reg;
                    state_next     = SEND;
                end
            end
            SEND: begin
                if (done) begin
                    // A sample arriving on the completing edge is newer than any pending one.
                    if (valid_in) begin
                        xpos_hold_next  = xpos_in;
                        ypos_hold_next  = ypos_in;
                        req_next        = ~req_reg;
                        pend_valid_next = 1'b0;
                        if (pend_valid_reg) drop_next = drop_inc;
                    end else if (pend_valid_reg) begin
                        xpos_hold_next  = xpos_pend_reg;
                        ypos_hold_next  = ypos_pend_reg;
                        req_next        = ~req_reg;
                        pend_valid_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (valid_in) begin
                    xpos_pend_next  = xpos_in;
                    ypos_pend_next  = ypos_in;
                    pend_valid_next = 1'b1;
                    if (pend_valid_reg) drop_next = drop_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            state_reg      <= IDLE;
            ack_sync_reg   <= '0;
            xpos_hold_reg  <= '0;
            ypos_hold_reg  <= '0;
            xpos_pend_reg  <= '0;
            ypos_pend_reg  <= '0;
            pend_valid_reg <= 1'b0;
            req_reg        <= 1'b0;
            drop_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            ack_sync_reg   <= {ack_sync_reg[SYNC_STAGES-2:0], ack_toggle_in};
            xpos_hold_reg  <= xpos_hold_next;
            ypos_hold_reg  <= ypos_hold_next;
            xpos_pend_reg  <= xpos_pend_next;
            ypos_pend_reg  <= ypos_pend_next;
            pend_valid_reg <= pend_valid_next;
            req_reg        <= req_next;
            drop_reg       <= drop_next;
        end
    end

    assign xpos_hold  = xpos_hold_reg;
    assign ypos_hold  = ypos_hold_reg;
    assign req_toggle = req_reg;
    assign busy       = (state_reg == SEND);
    assign drop_cnt   = drop_reg;

endmodule

// File: tb/tb_pos_sync_sender.sv
// Bench for pos_sync_sender: vector table, hand-written corner sequences, then random traffic
// against a transaction-level model (launch count, pending word, delayed ack samples).
module tb_pos_sync_sender;
    localparam int W    = 12;
    localparam int SYNC = 2;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  xpos_in = '0, ypos_in = '0;
    logic          valid_in = 1'b0, ack_toggle_in = 1'b0;
    logic [W-1:0]  xpos_hold, ypos_hold;
    logic          req_toggle, busy;
    logic [CW-1:0] drop_cnt;

    int checks = 0;
    int failures = 0;

    pos_sync_sender #(.WIDTH(W), .SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
        .clk100MHz(clk), .rst(rst), .xpos_in(xpos_in), .ypos_in(ypos_in),
        .valid_in(valid_in), .ack_toggle_in(ack_toggle_in),
        .xpos_hold(xpos_hold), .ypos_hold(ypos_hold), .req_toggle(req_toggle),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         r, v, a;
        logic [W-1:0] x, y;
        logic         e_busy, e_req;
        logic [W-1:0] e_x, e_y;
        int           e_drop;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic r, v, input int x, y, input logic a,
                       input logic eb, er, input int ex, ey, ed);
        vec_t t;
        t.r = r; t.v = v; t.a = a; t.x = W'(x); t.y = W'(y);
        t.e_busy = eb; t.e_req = er; t.e_x = W'(ex); t.e_y = W'(ey); t.e_drop = ed;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, v, input int x, y, input logic a);
        rst = r; valid_in = v; xpos_in = W'(x); ypos_in = W'(y); ack_toggle_in = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic eb, er, input int ex, ey, ed);
        check({tag, ".busy"}, int'(busy), int'(eb));
        check({tag, ".req"},  int'(req_toggle), int'(er));
        check({tag, ".x"},    int'(xpos_hold), ex);
        check({tag, ".y"},    int'(ypos_hold), ey);
        check({tag, ".drop"}, int'(drop_cnt), ed);
    endtask

    // Transaction-level reference model
    int           m_launches, m_drops;
    logic         m_busy, m_pend_v;
    logic [W-1:0] m_hx, m_hy, m_px, m_py;
    logic         m_ack_pipe[SYNC];

    function automatic logic m_req();
        return logic'(m_launches % 2);
    endfunction

    task automatic m_launch(input logic [W-1:0] x, y);
        m_hx = x; m_hy = y; m_launches++; m_busy = 1'b1;
    endtask

    task automatic model_edge(input logic r, v, input logic [W-1:0] x, y, input logic a);
        logic done;
        if (r) begin
            m_launches = 0; m_drops = 0; m_busy = 0; m_pend_v = 0;
            m_hx = '0; m_hy = '0; m_px = '0; m_py = '0;
            for (int i = 0; i < SYNC; i++) m_ack_pipe[i] = 1'b0;
            return;
        end
        done = (m_ack_pipe[SYNC-1] == m_req());
        if (!m_busy) begin
            if (v) m_launch(x, y);
        end else if (done) begin
            if (v) begin
                if (m_pend_v) m_drops++;
                m_pend_v = 0;
                m_launch(x, y);
            end else if (m_pend_v) begin
                m_pend_v = 0;
                m_launch(m_px, m_py);
            end else begin
                m_busy = 0;
            end
        end else if (v) begin
            if (m_pend_v) m_drops++;
            m_px = x; m_py = y; m_pend_v = 1;
        end
        for (int i = SYNC - 1; i > 0; i--) m_ack_pipe[i] = m_ack_pipe[i-1];
        m_ack_pipe[0] = a;
    endtask

    initial begin
        // reset, single transfer, reset, coalescing
        for (int i = 0; i < 3; i++) add(1, 1, 'h123, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,         0, 0, 0, 0, 0);
        add(0, 1, 'h2A0, 'h1F4, 0, 1, 1, 'h2A0, 'h1F4, 0);
        add(0, 0, 0, 0, 0,         1, 1, 'h2A0, 'h1F4, 0);
        add(0, 0, 0, 0, 0,         1, 1, 'h2A0, 'h1F4, 0);
        add(0, 0, 0, 0, 1,         1, 1, 'h2A0, 'h1F4, 0);
        add(0, 0, 0, 0, 1,         1, 1, 'h2A0, 'h1F4, 0);
        add(0, 0, 0, 0, 1,         0, 1, 'h2A0, 'h1F4, 0);
        add(0, 0, 0, 0, 1,         0, 1, 'h2A0, 'h1F4, 0);
        add(1, 0, 0, 0, 0,         0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,         0, 0, 0, 0, 0);
        add(0, 1, 'h0AA, 'h0BB, 0, 1, 1, 'h0AA, 'h0BB, 0);
        add(0, 1, 'h010, 'h011, 0, 1, 1, 'h0AA, 'h0BB, 0);
        add(0, 1, 'h020, 'h021, 0, 1, 1, 'h0AA, 'h0BB, 1);
        add(0, 1, 'h030, 'h031, 0, 1, 1, 'h0AA, 'h0BB, 2);
        add(0, 0, 0, 0, 1,         1, 1, 'h0AA, 'h0BB, 2);
        add(0, 0, 0, 0, 1,         1, 1, 'h0AA, 'h0BB, 2);
        add(0, 0, 0, 0, 1,         1, 0, 'h030, 'h031, 2);
        add(0, 0, 0, 0, 1,         1, 0, 'h030, 'h031, 2);
        add(0, 0, 0, 0, 0,         1, 0, 'h030, 'h031, 2);
        add(0, 0, 0, 0, 0,         1, 0, 'h030, 'h031, 2);
        add(0, 0, 0, 0, 0,         0, 0, 'h030, 'h031, 2);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].v, int'(vecs[i].x), int'(vecs[i].y), vecs[i].a);
            check_all($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_req,
                      int'(vecs[i].e_x), int'(vecs[i].e_y), vecs[i].e_drop);
        end

        // Simultaneous: new sample on the completing edge beats pending 0x044
        drive(0, 1, 'h033, 'h034, 0);
        check_all("sim.launch", 1, 1, 'h033, 'h034, 2);
        drive(0, 1, 'h044, 'h045, 1);
        check_all("sim.pend", 1, 1, 'h033, 'h034, 2);
        drive(0, 0, 0, 0, 1);
        drive(0, 1, 'h055, 'h056, 1);
        check_all("sim.win", 1, 0, 'h055, 'h056, 3);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("sim.busy_hold", int'(busy), 1);
        drive(0, 0, 0, 0, 0);
        check_all("sim.idle", 0, 0, 'h055, 'h056, 3);

        // Saturation: 300 pulses while ack stays behind
        drive(0, 1, 'h077, 'h078, 0);
        for (int i = 0; i < 300; i++) drive(0, 1, i, i + 1, 0);
        check_all("sat", 1, 1, 'h077, 'h078, 255);
        drive(0, 1, 'h0FF, 0, 0);
        check("sat.hold", int'(drop_cnt), 255);

        // Reset mid-transfer with a pending sample
        drive(1, 0, 0, 0, 0);
        check_all("rst_mid", 0, 0, 0, 0, 0);
        drive(0, 1, 'h0C3, 'h0D4, 0);
        check_all("rst_mid.relaunch", 1, 1, 'h0C3, 'h0D4, 0);

        // Random traffic against the model; receiver echoes the model request now and then
        begin
            logic r, v, a;
            logic [W-1:0] x, y;
            model_edge(1, 0, '0, '0, 0);
            drive(1, 0, 0, 0, 0);
            a = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                r = ($urandom_range(0, 299) == 0);
                v = ($urandom_range(0, 2) == 0);
                x = W'($urandom);
                y = W'($urandom);
                if ($urandom_range(0, 4) == 0) a = m_req();
                model_edge(r, v, x, y, a);
                drive(r, v, int'(x), int'(y), a);
                check_all($sformatf("rnd%0d", c), m_busy, m_req(), int'(m_hx), int'(m_hy),
                          (m_drops > 255) ? 255 : m_drops);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
